// File: rtl/dip_scan_ctrl.sv
// dip_scan_ctrl: periodically loads and shifts out an external switch shift
// chain, assembles each frame MSB-first and publishes it with a valid/ack
// handshake plus change and overrun pulses.
// Optional build macro DIP_SCAN_DEBOUNCE_EN: a frame is published only when it
// matches the frame captured just before it (two consecutive equal reads).
//
// state | meaning
// IDLE  | not scanning, waiting for enable
// LOAD  | dip_latch low, chain parallel-loads the switches (2*CLK_DIV cycles)
// SHIFT | dip_sclk toggles every CLK_DIV cycles, one sample per rising edge
// GAP   | IDLE_GAP quiet cycles, then LOAD again or IDLE if enable dropped
module dip_scan_ctrl #(
    parameter int FRAME_BITS = 24,
    parameter int CLK_DIV    = 4,
    parameter int IDLE_GAP   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dip_in,
    output logic                  dip_latch,
    output logic                  dip_sclk,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  frame_changed,
    output logic                  overrun,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam int CNT_W = 10;
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LOAD_RELOAD = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(IDLE_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_TOP     = BIT_W'(FRAME_BITS - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-2:0]   shift_reg;
    logic [FRAME_BITS-1:0]   frame_new;
    logic                    cnt_zero;
    logic                    half_end;
    logic                    sample_en;
    logic                    last_sample;
    logic                    publish;

    assign cnt_zero  = (cnt == '0);
    // The last sample goes straight to frame_new so it can publish on its own edge.
    assign frame_new = {shift_reg, dip_in};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt   = state;
        dip_latch   = 1'b1;
        busy        = 1'b1;
        half_end    = 1'b0;
        sample_en   = 1'b0;
        last_sample = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                dip_latch = 1'b0;
                if (cnt_zero) state_nxt = SHIFT;
            end
            SHIFT: begin
                half_end    = cnt_zero;
                sample_en   = cnt_zero && !dip_sclk;
                last_sample = sample_en && (bit_cnt == '0);
                if (cnt_zero && dip_sclk && (bit_cnt == '0)) state_nxt = GAP;
            end
            GAP: begin
                if (cnt_zero) state_nxt = enable ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Down-counter: reloaded on state entry and at each sclk half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                LOAD:    cnt <= LOAD_RELOAD;
                SHIFT:   cnt <= HALF_RELOAD;
                GAP:     cnt <= GAP_RELOAD;
                default: cnt <= '0;
            endcase
        end else if (state == SHIFT && cnt_zero) begin
            cnt <= HALF_RELOAD;
        end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Shift clock generation, bit counting and sample capture on sclk rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dip_sclk  <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state != SHIFT) begin
            dip_sclk <= 1'b0;
            bit_cnt  <= BIT_TOP;
        end else if (half_end) begin
            dip_sclk <= ~dip_sclk;
            if (sample_en) begin
                shift_reg <= frame_new[FRAME_BITS-2:0];
            end else if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - BIT_W'(1);
            end
        end
    end

`ifdef DIP_SCAN_DEBOUNCE_EN
    logic [FRAME_BITS-1:0] raw_shadow;

    // Remember every completed raw frame; publish only on two equal reads in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_shadow <= '0;
        end else if (last_sample) begin
            raw_shadow <= frame_new;
        end
    end

    assign publish = last_sample && (frame_new == raw_shadow);
`else
    assign publish = last_sample;
`endif

    // Publication, valid/ack handshake and one-cycle change/overrun pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_changed <= 1'b0;
            overrun       <= 1'b0;
            if (publish) begin
                frame_data    <= frame_new;
                frame_valid   <= 1'b1;
                frame_changed <= (frame_new != frame_data);
                overrun       <= frame_valid & ~frame_ack;
            end else if (frame_valid && frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
